// File: rtl/ifu_pc.sv
// Instruction-fetch PC unit: next-PC selection, fetch-window legality check,
// sticky fetch fault and a committed-advance counter.
module ifu_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [9:0]  im_addr,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_plus8,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        RUN,
        FAULT
    } state_t;

    // Window bounds kept at 33 bits so IM_BASE + 4*IM_WORDS cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, IM_BASE};
    localparam logic [32:0] WIN_HI = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] count_reg, count_next;
    logic [31:0] npc;
    logic [31:0] br_offset;
    logic        npc_legal;

    assign pc          = pc_reg;
    assign pc_plus4    = pc_reg + 32'd4;
    assign pc_plus8    = pc_reg + 32'd8;
    assign im_addr     = 10'((pc_reg - IM_BASE) >> 2);
    assign fetch_fault = (state_reg == FAULT);
    assign fetch_count = count_reg;

    assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        npc = pc_plus4;
        case (npc_sel)
            2'b00: npc = pc_plus4;
            2'b01: npc = br_taken ? (pc_plus4 + br_offset) : pc_plus4;
            2'b10: npc = {pc_plus4[31:28], instr_index, 2'b00};
            2'b11: npc = jr_target;
            default: npc = pc_plus4;
        endcase
    end

    assign npc_legal = (npc[1:0] == 2'b00)
                    && ({1'b0, npc} >= WIN_LO)
                    && ({1'b0, npc} <  WIN_HI);

    // A stalled cycle never evaluates legality, so an illegal npc under stall
    // cannot trip the fault.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        count_next = count_reg;
        case (state_reg)
            RUN: begin
                if (!stall) begin
                    if (npc_legal) begin
                        pc_next    = npc;
                        count_next = count_reg + 32'd1;
                    end else begin
                        state_next = FAULT;
                    end
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: state_next = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
            pc_reg    <= RESET_PC;
            count_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            count_reg <= count_next;
        end
    end

endmodule

// File: tb/tb_ifu_pc.sv
// Directed bench for ifu_pc: stimulus pushes hand-computed expectations into a
// queue, a monitor on the falling edge pops and compares them.
module tb_ifu_pc;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [9:0]  im_addr;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [9:0]  im_addr;
        logic        fault;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    ifu_pc dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .npc_sel     (npc_sel),
        .br_taken    (br_taken),
        .imm16       (imm16),
        .instr_index (instr_index),
        .jr_target   (jr_target),
        .pc          (pc),
        .im_addr     (im_addr),
        .pc_plus4    (pc_plus4),
        .pc_plus8    (pc_plus8),
        .fetch_fault (fetch_fault),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every falling edge, check all expectations pushed since.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic bad;
            e = exp_q.pop_front();
            bad = 1'b0;
            n_vec++;
            if (pc !== e.pc) begin
                $display("FAIL %s pc: got %h expected %h", e.name, pc, e.pc);
                bad = 1'b1;
            end
            if (im_addr !== e.im_addr) begin
                $display("FAIL %s im_addr: got %h expected %h", e.name, im_addr, e.im_addr);
                bad = 1'b1;
            end
            if (pc_plus4 !== e.pc + 32'd4) begin
                $display("FAIL %s pc_plus4: got %h expected %h", e.name, pc_plus4, e.pc + 32'd4);
                bad = 1'b1;
            end
            if (pc_plus8 !== e.pc + 32'd8) begin
                $display("FAIL %s pc_plus8: got %h expected %h", e.name, pc_plus8, e.pc + 32'd8);
                bad = 1'b1;
            end
            if (fetch_fault !== e.fault) begin
                $display("FAIL %s fetch_fault: got %b expected %b", e.name, fetch_fault, e.fault);
                bad = 1'b1;
            end
            if (fetch_count !== e.count) begin
                $display("FAIL %s fetch_count: got %0d expected %0d", e.name, fetch_count, e.count);
                bad = 1'b1;
            end
            if (bad) n_mis++;
            $display("vec %0d %s: pc=%h im=%h fault=%b cnt=%0d", n_vec, e.name,
                     pc, im_addr, fetch_fault, fetch_count);
        end
    end

    task automatic step(input string nm, input logic rst, input logic st,
                        input logic [1:0] sel, input logic br, input logic [15:0] imm,
                        input logic [25:0] idx, input logic [31:0] jr,
                        input logic [31:0] epc, input logic [9:0] eim,
                        input logic ef, input logic [31:0] ecnt);
        exp_t e;
        reset       = rst;
        stall       = st;
        npc_sel     = sel;
        br_taken    = br;
        imm16       = imm;
        instr_index = idx;
        jr_target   = jr;
        @(posedge clk);
        #1;
        e.name    = nm;
        e.pc      = epc;
        e.im_addr = eim;
        e.fault   = ef;
        e.count   = ecnt;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; npc_sel = 2'b00; br_taken = 1'b0;
        imm16 = '0; instr_index = '0; jr_target = '0;

        // 1: reset and sequential fetch
        step("reset",   1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 10'd0, 0, 0);
        step("seq1",    0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 10'd1, 0, 1);
        step("seq2",    0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 10'd2, 0, 2);
        step("seq3",    0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h300C, 10'd3, 0, 3);
        step("seq4",    0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3010, 10'd4, 0, 4);
        // 2: backward branch taken, then not taken from the same pc
        step("br_tkn",  0, 0, 2'b01, 1, 16'hFFFC, 26'h0, 32'h0, 32'h3004, 10'd1, 0, 5);
        step("seq5",    0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 10'd2, 0, 6);
        step("seq6",    0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h300C, 10'd3, 0, 7);
        step("seq7",    0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3010, 10'd4, 0, 8);
        step("br_ntkn", 0, 0, 2'b01, 0, 16'hFFFC, 26'h0, 32'h0, 32'h3014, 10'd5, 0, 9);
        // 3: jump
        step("reset2",  1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 10'd0, 0, 0);
        step("jump",    0, 0, 2'b10, 0, 16'h0, 26'h0000C10, 32'h0, 32'h3040, 10'h010, 0, 1);
        // 4: stall holds, even with an illegal target, then jr on release
        for (int i = 0; i < 4; i++)
            step("stall",   0, 1, 2'b11, 0, 16'h0, 26'h0, 32'h3100, 32'h3040, 10'h010, 0, 1);
        step("stall_bad", 0, 1, 2'b11, 0, 16'h0, 26'h0, 32'h3102, 32'h3040, 10'h010, 0, 1);
        step("jr",      0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h3100, 32'h3100, 10'h040, 0, 2);
        // 5: misaligned target faults and freezes until reset
        step("misalgn", 0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h3102, 32'h3100, 10'h040, 1, 2);
        step("frozen",  0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h3004, 32'h3100, 10'h040, 1, 2);
        step("frozen2", 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3100, 10'h040, 1, 2);
        step("reset3",  1, 0, 2'b11, 0, 16'h0, 26'h0, 32'h3004, 32'h3000, 10'd0, 0, 0);
        // 6: window boundaries
        step("hi_out",  0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h4000, 32'h3000, 10'd0, 1, 0);
        step("reset4",  1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 10'd0, 0, 0);
        step("hi_in",   0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h3FFC, 32'h3FFC, 10'd1023, 0, 1);
        step("reset5",  1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 10'd0, 0, 0);
        step("lo_out",  0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h2FFC, 32'h3000, 10'd0, 1, 0);
        // Reset while stalled mid-run
        step("reset6",  1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 10'd0, 0, 0);
        step("seq8",    0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 10'd1, 0, 1);
        step("rst_stl", 1, 1, 2'b11, 0, 16'h0, 26'h0, 32'h3200, 32'h3000, 10'd0, 0, 0);

        reset = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
            n_mis++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/ifu_pc.md
Name: ifu_pc

Overview:
- Instruction-fetch front end that sits directly upstream of the 4 KB instruction memory.
- Holds the program counter and computes the next PC: sequential, conditional branch, j/jal, or jr.
- Drives the memory word address (bits [11:2]) and supplies pc+4 and pc+8 for link and branch logic.
- Flags illegal fetch targets with a sticky fault that freezes fetch until reset.
- Counts committed PC advances for debug.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded by reset.
- IM_BASE, 32'h0000_3000, byte address that maps to instruction-memory word 0.
- IM_WORDS, 1024, number of 32-bit words in instruction memory; the legal fetch window is [IM_BASE, IM_BASE+4*IM_WORDS).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold the PC this cycle.
- npc_sel  in  2  next-PC source: 00 sequential, 01 branch, 10 jump (j/jal), 11 register (jr).
- br_taken  in  1  branch condition result; used only when npc_sel=01.
- imm16  in  16  branch offset field.
- instr_index  in  26  jump target field.
- jr_target  in  32  register-sourced target.
- pc  out  32  current PC.
- im_addr  out  10  word address to instruction memory, bits [11:2].
- pc_plus4  out  32  pc+4.
- pc_plus8  out  32  pc+8 (jal link value).
- fetch_fault  out  1  sticky illegal-target flag.
- fetch_count  out  32  number of committed PC updates since reset.

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk.
  - It has priority over every other input.
  - After reset: pc=RESET_PC, fetch_fault=0, fetch_count=0.
  - pc_plus4, pc_plus8 and im_addr follow combinationally from pc.
- Combinational outputs:
  - pc_plus4=pc+4, pc_plus8=pc+8; both wrap modulo 2^32.
  - im_addr=(pc-IM_BASE)[11:2]. At reset this gives im_addr=0.
- Candidate next PC (npc), combinational:
  - 00: pc+4.
  - 01 with br_taken=1: pc+4 + (sign_extend(imm16)<<2), modulo 2^32.
  - 01 with br_taken=0: pc+4.
  - 10: {pc_plus4[31:28], instr_index, 2'b00}.
  - 11: jr_target, unmodified.
- Legality check on npc:
  - npc is illegal if npc[1:0]!=0, or npc<IM_BASE, or npc>=IM_BASE+4*IM_WORDS.
  - Comparisons are unsigned, 33-bit, so the window end does not overflow.
- State machine: RUN and FAULT; fetch_fault=1 exactly in FAULT.
  - RUN, stall=1: pc and fetch_count hold. No fault check is made, even if npc is illegal.
  - RUN, stall=0, npc legal: pc<=npc, fetch_count<=fetch_count+1, stay in RUN.
  - RUN, stall=0, npc illegal: pc holds at the last legal value, fetch_count holds, go to FAULT.
  - FAULT: pc and fetch_count frozen. All inputs ignored except reset. The only exit is reset.
- Latency: a redirect presented in cycle N appears on pc/im_addr after the edge ending cycle N. There is no delay slot handling inside this block.
- fetch_count wraps from 2^32-1 to 0. It never saturates.
- Reset asserted mid-stall or in FAULT: the next edge gives the full reset values.
- The stall input and the npc inputs may change every cycle. Only the values present at the edge matter.

Test Plan:
1. Reset, then 3 edges with npc_sel=00, stall=0:
   - pc goes 0x3000→0x3004→0x3008→0x300C.
   - im_addr=3 at the end; fetch_count=3; pc_plus8=0x3014.
2. pc=0x3010, npc_sel=01, imm16=16'hFFFC, br_taken=1:
   - pc=0x3004.
   - Repeat with br_taken=0: pc=0x3014.
3. pc=0x3000, npc_sel=10, instr_index=26'h0000C10:
   - pc=0x3040, im_addr=0x010.
4. stall=1 for 4 cycles, with npc_sel=11 and jr_target=0x3100:
   - pc and fetch_count unchanged throughout.
   - Release stall: pc=0x3100.
5. npc_sel=11, jr_target=0x3102 (misaligned):
   - fetch_fault=1 and pc held.
   - Further jr_target=0x3004 is ignored.
   - Reset: pc=0x3000, fetch_fault=0, fetch_count=0.
6. jr_target=0x4000 (=IM_BASE+4096) → fault.
   - After reset, jr_target=0x3FFC → legal, im_addr=1023.
   - After reset, jr_target=0x2FFC → fault.
